bcd_scan_display: RTL

//  Consumer end of the clock's BCD counter chain: takes NUM_DIGITS packed BCD digits (hh:mm:ss)
//  and drives a time-multiplexed 7-segment display, one digit per scan slot.

---
 rtl/bcd_disp_pkg.sv | 24 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_scan_display.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD scan display: BCD width, 7-segment patterns and bit order.
// Segment bit order is {g,f,e,d,c,b,a}; all patterns are logic-high (1 = segment lit).
package bcd_disp_pkg;

   localparam int unsigned BCD_W = 4;
   localparam int unsigned SEG_W = 7;

   typedef logic [BCD_W-1:0] bcd_t;
   typedef logic [SEG_W-1:0] seg7_t;

   localparam seg7_t SEG7_0     = 7'h3F;
   localparam seg7_t SEG7_1     = 7'h06;
   localparam seg7_t SEG7_2     = 7'h5B;
   localparam seg7_t SEG7_3     = 7'h4F;
   localparam seg7_t SEG7_4     = 7'h66;
   localparam seg7_t SEG7_5     = 7'h6D;
   localparam seg7_t SEG7_6     = 7'h7D;
   localparam seg7_t SEG7_7     = 7'h07;
   localparam seg7_t SEG7_8     = 7'h7F;
   localparam seg7_t SEG7_9     = 7'h6F;
   localparam seg7_t SEG7_DASH  = 7'h40;
   localparam seg7_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder (logic-high). Codes 10..15 decode to a dash.
module bcd_to_seg7
   import bcd_disp_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [SEG_W-1:0] seg
);

   // Digit lookup; anything that is not a decimal digit shows as '-'
   always_comb begin
      seg = SEG7_DASH;
      case (bcd)
         4'd0:    seg = SEG7_0;
         4'd1:    seg = SEG7_1;
         4'd2:    seg = SEG7_2;
         4'd3:    seg = SEG7_3;
         4'd4:    seg = SEG7_4;
         4'd5:    seg = SEG7_5;
         4'd6:    seg = SEG7_6;
         4'd7:    seg = SEG7_7;
         4'd8:    seg = SEG7_8;
         4'd9:    seg = SEG7_9;
         default: seg = SEG7_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment driver for NUM_DIGITS packed BCD digits.
// Digits are snapshotted once per frame so a frame never mixes old and new values.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros (digit 0 never blanked).
module bcd_scan_display
   import bcd_disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 6,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned SEG_ACTIVE_LOW = 1
) (
   input  logic                        CP,
   input  logic                        CR,
   input  logic                        EN,
   input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   output logic [NUM_DIGITS-1:0]       AN,
   output logic [SEG_W-1:0]            SEG,
   output logic                        DP,
   output logic                        frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam bit INVERT = (SEG_ACTIVE_LOW != 0);
`ifdef LEADING_ZERO_BLANK_EN
   // Reset snapshot is all zeros, so only digit 0 is visible until the first snapshot
   localparam logic [NUM_DIGITS-1:0] BLANK_RST = {NUM_DIGITS{1'b1}} << 1;
`else
   localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

   logic [CNT_W-1:0]            presc_q;
   logic [IDX_W-1:0]            idx_q;
   logic [BCD_W*NUM_DIGITS-1:0] snap_q;
   logic [NUM_DIGITS-1:0]       snap_dp_q;
   logic [NUM_DIGITS-1:0]       blank_q;
   logic [NUM_DIGITS-1:0]       blank_d;
   logic                        frame_q;
   logic [NUM_DIGITS-1:0]       an_q;
   logic [SEG_W-1:0]            seg_q;
   logic                        dp_q;
   logic [NUM_DIGITS-1:0]       an_d;
   logic [SEG_W-1:0]            seg_d;
   logic                        dp_d;
   logic [BCD_W-1:0]            cur_bcd;
   logic [SEG_W-1:0]            cur_seg;
   logic                        tick;
   logic                        wrap;

   assign tick = EN && (presc_q == CNT_LAST);
   assign wrap = tick && (idx_q == IDX_LAST);

   // Prescaler and scan index; both freeze while EN is low
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else if (EN) begin
         presc_q <= tick ? '0 : presc_q + CNT_W'(1);
         if (tick) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lead;

   // Blank zeros from the top digit down until the first nonzero; digit 0 always shown
   always_comb begin
      blank_d = '0;
      lead    = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         if (lead && (digits_in[k*BCD_W +: BCD_W] == 4'd0)) begin
            blank_d[k] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   assign blank_d = '0;
`endif

   // Frame snapshot, taken on the same edge that idx wraps back to 0
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         snap_q    <= '0;
         snap_dp_q <= '0;
         blank_q   <= BLANK_RST;
         frame_q   <= 1'b0;
      end else begin
         frame_q <= wrap;
         if (wrap) begin
            snap_q    <= digits_in;
            snap_dp_q <= dp_in;
            blank_q   <= blank_d;
         end
      end
   end

   assign cur_bcd = snap_q[{idx_q, 2'b00} +: BCD_W];

   bcd_to_seg7 u_dec (
      .bcd (cur_bcd),
      .seg (cur_seg)
   );

   // Next output pattern for the current slot (logic-high)
   always_comb begin
      an_d        = '0;
      an_d[idx_q] = 1'b1;
      seg_d       = blank_q[idx_q] ? SEG7_BLANK : cur_seg;
      dp_d        = snap_dp_q[idx_q];
   end

   // Registered output stage; holds while EN is low
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         an_q  <= '0;
         seg_q <= '0;
         dp_q  <= 1'b0;
      end else if (EN) begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign AN         = INVERT ? ~an_q  : an_q;
   assign SEG        = INVERT ? ~seg_q : seg_q;
   assign DP         = INVERT ? ~dp_q  : dp_q;
   assign frame_done = frame_q && EN;

endmodule
